calc_r_pipelined: RTL and testbench
===================================

// Module: calc_r_pipelined
// PURPOSE
//  Streaming, parametrised successor to the combinational R-from-(y,theta) calc: r = y/sin(theta),
//  with r = x at theta index 0. Uses a Q-format 1/sin ROM, a 3-stage pipeline, valid/ready
//  handshakes, round-to-nearest, output saturation and bad-angle flagging.
//  Sits between the ultrasound angle/distance front end and the polar-to-screen mapper.
// PARAMETERS
//  IN_W        8  width of x, y inputs (unsigned)
//  OUT_W       8  width of r (unsigned)
//  THETA_W     4  width of theta index
//  N_STEPS     6  number of 15-degree steps in 0..90; valid theta indices are 0..N_STEPS
//  COEF_FRAC   8  fraction bits of 1/sin coefficients (coef 256 = 1.0)
//  SCALE_SHIFT 2  extra right shift; 2 means output units are 4 inches
// PORTS
//  clock      in   1        system clock, rising edge
//  reset_n    in   1        asynchronous, active-low reset
//  in_valid   in   1        x, y and theta are valid
//  in_ready   out  1        block accepts input this cycle
//  x          in   IN_W     horizontal distance; used when theta == 0
//  y          in   IN_W     vertical distance; used when theta is 1..N_STEPS
//  theta      in   THETA_W  angle index, step 15 deg (0 = 0 deg, 6 = 90 deg)
//  out_valid  out  1        r, sat and bad_theta are valid
//  out_ready  in   1        downstream accepts output
//  r          out  OUT_W    range result
//  sat        out  1        result clipped to all-ones
//  bad_theta  out  1        theta > N_STEPS; r forced to 0
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits 0, out_valid=0, r=0, sat=0, bad_theta=0.
//  - advance = !out_valid || out_ready. in_ready = advance (combinational). All stages shift on advance.
//  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
//  - Latency 3 cycles from input transfer to out_valid with no backpressure. Throughput 1 per cycle.
//  - S1: register src = (theta==0) ? x : y; coef = ROM[theta]; bad = theta > N_STEPS.
//  - S2: prod = src*coef, width IN_W+COEF_FRAC+3, no overflow.
//  - S3: q = (prod + 2^(SH-1)) >> SH with SH = COEF_FRAC+SCALE_SHIFT (round half up; if SH = 0, no add).
//    If bad: r=0, sat=0, bad_theta=1. Else if q > 2^OUT_W-1: r=all ones, sat=1. Else r=q, sat=0.
//  - ROM (COEF_FRAC=8): idx 0->256, 1->989, 2->512, 3->362, 4->296, 5->265, 6->256; other idx -> 0.
//    For other COEF_FRAC values, the entry is round(2^COEF_FRAC / sin(15*idx deg)).
//  - Stall: while out_valid && !out_ready, every stage holds; r/sat/bad_theta stay stable.
//  - Bubbles: invalid stages carry valid=0; data regs may hold stale values; out_valid follows S3 valid.
//  - reset_n asserted mid-stream: in-flight items are dropped; no output appears after release
//    until new inputs arrive.
// STRUCTURE
//  - Shared package/include calc_r_defs.vh: 15-deg step constant, INV_SIN_Q8 table, THETA_0/THETA_90 indices.
//  - One sub-module, inv_sin_rom (theta -> coef, combinational). Pipeline and handshake are in the top.
// TESTING
//  1 y=100, theta=1, out_ready=1 -> 3 cycles later r=97, sat=0, bad_theta=0.
//  2 y=200, theta=2 -> r=100; x=255, theta=0 -> r=64; y=40, theta=6 -> r=10 (back-to-back, in order).
//  3 SCALE_SHIFT=0 instance: y=100, theta=1 -> r=255, sat=1; y=100, theta=6 -> r=100, sat=0.
//  4 theta=7, y=50 -> r=0, bad_theta=1, sat=0.
//  5 Stream 5 items, drop out_ready for 4 cycles -> in_ready=0 during the stall, output held stable,
//    no loss or duplication, order kept.
//  6 reset_n low for 1 cycle with 3 items in flight -> out_valid=0 immediately, r=0, and no stale output later.

Source files
------------

// File: rtl/calc_r_pipelined_pkg.sv
// ----------------------------------------------------------------------------
// calc_r_pipelined_pkg
//   Shared constants for the r = y / sin(theta) pipeline:
//   - angle step size and the 0 / 90 degree theta indices
//   - 1/sin coefficient tables (Q8 reference, Q16 master for other formats)
//   - inv_sin_coef(): coefficient for a given index and fraction width
// ----------------------------------------------------------------------------
package calc_r_pipelined_pkg;

  localparam int STEP_DEG = 15;
  localparam int THETA_0  = 0;
  localparam int THETA_90 = 6;
  localparam int N_TBL    = THETA_90 + 1;

  // Index 0 is 1.0 because at 0 degrees r is taken straight from x.
  localparam int INV_SIN_Q8 [0:N_TBL-1] = '{256, 989, 512, 362, 296, 265, 256};

  // round(65536 / sin(15*idx deg)); other fraction widths are rounded from this.
  localparam int INV_SIN_Q16 [0:N_TBL-1] =
    '{65536, 253212, 131072, 92682, 75674, 67848, 65536};

  // The Q8 table is returned verbatim so the 8-bit format matches the
  // published values exactly instead of going through a second rounding.
  // Fraction widths above 16 are not meaningful for 8-bit data and are
  // produced by a plain left shift of the Q16 value.
  function automatic int inv_sin_coef(input int idx, input int frac);
    if (idx < 0 || idx >= N_TBL) return 0;
    if (frac == 8)  return INV_SIN_Q8[idx];
    if (frac >= 16) return INV_SIN_Q16[idx] << (frac - 16);
    return (INV_SIN_Q16[idx] + (1 << (15 - frac))) >> (16 - frac);
  endfunction

endpackage

// File: rtl/calc_r_pipelined_if.sv
// ----------------------------------------------------------------------------
// calc_r_pipelined_if
//   Input and output valid/ready streams of calc_r_pipelined.
//   Input side : in_valid, in_ready, x, y, theta
//   Output side: out_valid, out_ready, r, sat, bad_theta
//   master = upstream source / downstream sink (testbench or neighbours)
//   slave  = the calc_r_pipelined block
// ----------------------------------------------------------------------------
interface calc_r_pipelined_if #(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 8,
  parameter int THETA_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    x;
  logic [IN_W-1:0]    y;
  logic [THETA_W-1:0] theta;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   r;
  logic               sat;
  logic               bad_theta;

  modport master (
    output in_valid, x, y, theta, out_ready,
    input  in_ready, out_valid, r, sat, bad_theta
  );

  modport slave (
    input  in_valid, x, y, theta, out_ready,
    output in_ready, out_valid, r, sat, bad_theta
  );
endinterface

// File: rtl/calc_r_pipelined_inv_sin_rom.sv
// ----------------------------------------------------------------------------
// inv_sin_rom
//   Combinational 1/sin lookup, coefficient in Q(COEF_FRAC).
//   i_theta : angle index (15 degree steps)
//   o_coef  : 2^COEF_FRAC / sin(theta); 0 for indices outside 0..N_STEPS
// ----------------------------------------------------------------------------
module inv_sin_rom
  import calc_r_pipelined_pkg::*;
#(
  parameter int THETA_W   = 4,
  parameter int N_STEPS   = 6,
  parameter int COEF_FRAC = 8,
  parameter int COEF_W    = COEF_FRAC + 2
) (
  input  logic [THETA_W-1:0] i_theta,
  output logic [COEF_W-1:0]  o_coef
);

  localparam logic [COEF_W-1:0] TBL [0:N_TBL-1] = '{
    COEF_W'(inv_sin_coef(0, COEF_FRAC)),
    COEF_W'(inv_sin_coef(1, COEF_FRAC)),
    COEF_W'(inv_sin_coef(2, COEF_FRAC)),
    COEF_W'(inv_sin_coef(3, COEF_FRAC)),
    COEF_W'(inv_sin_coef(4, COEF_FRAC)),
    COEF_W'(inv_sin_coef(5, COEF_FRAC)),
    COEF_W'(inv_sin_coef(6, COEF_FRAC))
  };

  always_comb begin
    o_coef = '0;
    for (int i = 0; i < N_TBL; i++) begin
      if (i <= N_STEPS && int'(i_theta) == i) o_coef = TBL[i];
    end
  end

endmodule

// File: rtl/calc_r_pipelined.sv
// ----------------------------------------------------------------------------
// calc_r_pipelined
//   Streaming r = y / sin(theta) (r = x at theta 0), 3-stage pipeline.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of calc_r_pipelined_if (input and output streams)
//   S1 selects the source and looks up 1/sin, S2 multiplies, S3 rounds,
//   scales, saturates and flags bad angles. All stages move together
//   whenever the output register is empty or being drained.
// ----------------------------------------------------------------------------
module calc_r_pipelined
  import calc_r_pipelined_pkg::*;
#(
  parameter int IN_W        = 8,
  parameter int OUT_W       = 8,
  parameter int THETA_W     = 4,
  parameter int N_STEPS     = 6,
  parameter int COEF_FRAC   = 8,
  parameter int SCALE_SHIFT = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  calc_r_pipelined_if.slave bus
);

  localparam int COEF_W = COEF_FRAC + 2;
  localparam int PROD_W = IN_W + COEF_FRAC + 3;
  localparam int SH     = COEF_FRAC + SCALE_SHIFT;
  localparam int RND_SH = (SH > 0) ? SH - 1 : 0;
  localparam logic [PROD_W-1:0] RND     = (SH > 0) ? (PROD_W'(1) << RND_SH) : '0;
  localparam logic [PROD_W-1:0] OUT_MAX = PROD_W'({OUT_W{1'b1}});

  logic              w_advance;
  logic [COEF_W-1:0] w_coef;
  logic [IN_W-1:0]   w_src;
  logic              w_bad;
  logic [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0] w_sum;
  logic [PROD_W-1:0] w_q;

  logic              r_v1;
  logic [IN_W-1:0]   r_src1;
  logic [COEF_W-1:0] r_coef1;
  logic              r_bad1;
  logic              r_v2;
  logic [PROD_W-1:0] r_prod2;
  logic              r_bad2;
  logic              r_v3;
  logic [OUT_W-1:0]  r_res3;
  logic              r_sat3;
  logic              r_bad3;

  inv_sin_rom #(
    .THETA_W   (THETA_W),
    .N_STEPS   (N_STEPS),
    .COEF_FRAC (COEF_FRAC),
    .COEF_W    (COEF_W)
  ) u_rom (
    .i_theta (bus.theta),
    .o_coef  (w_coef)
  );

  assign w_advance = !r_v3 || bus.out_ready;
  assign w_src     = (int'(bus.theta) == THETA_0) ? bus.x : bus.y;
  assign w_bad     = int'(bus.theta) > N_STEPS;

  // Coefficient < 4 * 2^COEF_FRAC, so the product always fits PROD_W.
  assign w_prod = PROD_W'(r_src1) * PROD_W'(r_coef1);
  // Product stays below 2^(PROD_W-1), so adding the half-LSB cannot wrap.
  assign w_sum  = r_prod2 + RND;
  assign w_q    = w_sum >> SH;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_v1    <= 1'b0;
      r_src1  <= '0;
      r_coef1 <= '0;
      r_bad1  <= 1'b0;
      r_v2    <= 1'b0;
      r_prod2 <= '0;
      r_bad2  <= 1'b0;
      r_v3    <= 1'b0;
      r_res3  <= '0;
      r_sat3  <= 1'b0;
      r_bad3  <= 1'b0;
    end else if (w_advance) begin
      r_v1    <= bus.in_valid;
      r_src1  <= w_src;
      r_coef1 <= w_coef;
      r_bad1  <= w_bad;

      r_v2    <= r_v1;
      r_prod2 <= w_prod;
      r_bad2  <= r_bad1;

      r_v3    <= r_v2;
      if (r_bad2) begin
        r_res3 <= '0;
        r_sat3 <= 1'b0;
        r_bad3 <= 1'b1;
      end else if (w_q > OUT_MAX) begin
        r_res3 <= '1;
        r_sat3 <= 1'b1;
        r_bad3 <= 1'b0;
      end else begin
        r_res3 <= w_q[OUT_W-1:0];
        r_sat3 <= 1'b0;
        r_bad3 <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_v3;
  assign bus.r         = r_res3;
  assign bus.sat       = r_sat3;
  assign bus.bad_theta = r_bad3;

endmodule

// File: tb/tb_calc_r_pipelined.sv
module tb_calc_r_pipelined;

  typedef struct {
    int r;
    int sat;
    int bad;
  } exp_t;

  logic clock;
  logic reset_n;

  calc_r_pipelined_if #(.IN_W(8), .OUT_W(8), .THETA_W(4)) bus ();
  calc_r_pipelined_if #(.IN_W(8), .OUT_W(8), .THETA_W(4)) bus0 ();

  calc_r_pipelined #(
    .IN_W(8), .OUT_W(8), .THETA_W(4), .N_STEPS(6), .COEF_FRAC(8), .SCALE_SHIFT(2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  calc_r_pipelined #(
    .IN_W(8), .OUT_W(8), .THETA_W(4), .N_STEPS(6), .COEF_FRAC(8), .SCALE_SHIFT(0)
  ) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  exp_t exp0_q[$];

  int ov_seen;
  int prev_stall;
  int held_r, held_sat, held_bad;

  // Reference: r = src / sin(theta) with src in 1/256 steps of a Q8 coefficient,
  // rounded half up, then clipped to 8 bits; angles above 90 deg are flagged.
  function automatic exp_t model(input int x, input int y, input int theta, input int shift);
    exp_t e;
    real  pi, c;
    int   coef, src, sh;
    longint q;
    pi = 3.14159265358979;
    if (theta > 6) begin
      e.r = 0; e.sat = 0; e.bad = 1;
      return e;
    end
    if (theta == 0) c = 256.0;
    else c = 256.0 / $sin(real'(theta) * 15.0 * pi / 180.0);
    coef = int'($floor(c + 0.5));
    src  = (theta == 0) ? x : y;
    sh   = 8 + shift;
    q    = (longint'(src) * coef + (longint'(1) << (sh - 1))) >>> sh;
    e.bad = 0;
    if (q > 255) begin e.r = 255; e.sat = 1; end
    else begin e.r = int'(q); e.sat = 0; end
    return e;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clock);
    ov_seen = int'(bus.out_valid);
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", int'(bus.out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        chk("r", int'(bus.r), e.r);
        chk("sat", int'(bus.sat), e.sat);
        chk("bad_theta", int'(bus.bad_theta), e.bad);
      end
    end
    if (bus.out_valid && !bus.out_ready) begin
      chk("stall_in_ready", int'(bus.in_ready), 0);
      if (prev_stall != 0) begin
        chk("stall_r_hold", int'(bus.r), held_r);
        chk("stall_sat_hold", int'(bus.sat), held_sat);
        chk("stall_bad_hold", int'(bus.bad_theta), held_bad);
      end
      held_r = int'(bus.r); held_sat = int'(bus.sat); held_bad = int'(bus.bad_theta);
      prev_stall = 1;
    end else begin
      prev_stall = 0;
    end
    if (bus.in_valid && bus.in_ready)
      exp_q.push_back(model(int'(bus.x), int'(bus.y), int'(bus.theta), 2));
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int v, input int x, input int y, input int th);
    bus.in_valid = (v != 0);
    bus.x        = 8'(x);
    bus.y        = 8'(y);
    bus.theta    = 4'(th);
  endtask

  initial begin
    prev_stall = 0;
    ov_seen    = 0;
    reset_n    = 1'b0;
    drive(0, 0, 0, 0);
    bus.out_ready  = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.x         = '0;
    bus0.y         = '0;
    bus0.theta     = '0;
    bus0.out_ready = 1'b1;

    // reset state
    #12;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_r", int'(bus.r), 0);
    chk("rst_sat", int'(bus.sat), 0);
    chk("rst_bad", int'(bus.bad_theta), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // single item, latency of 3 cycles
    drive(1, 0, 100, 1);
    step();
    drive(0, 0, 0, 0);
    step(); chk("lat_c1", ov_seen, 0);
    step(); chk("lat_c2", ov_seen, 0);
    step(); chk("lat_c3", ov_seen, 1);
    step();

    // back-to-back directed items
    drive(1, 0, 200, 2);   step();
    drive(1, 255, 0, 0);   step();
    drive(1, 0, 40, 6);    step();
    drive(1, 0, 50, 7);    step();
    drive(1, 9, 0, 15);    step();
    drive(0, 0, 0, 0);
    repeat (5) step();
    chk("directed_drain", exp_q.size(), 0);

    // 5-item stream then 4-cycle backpressure
    for (int i = 0; i < 5; i++) begin
      drive(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 6));
      step();
    end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 8));
      step();
    end
    bus.out_ready = 1'b1;
    drive(0, 0, 0, 0);
    repeat (8) step();
    chk("stall_drain", exp_q.size(), 0);

    // random traffic with random backpressure
    for (int i = 0; i < 80; i++) begin
      drive(($urandom % 4) != 0, $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 9));
      bus.out_ready = (($urandom % 3) != 0);
      step();
    end
    drive(0, 0, 0, 0);
    bus.out_ready = 1'b1;
    repeat (8) step();
    chk("random_drain", exp_q.size(), 0);

    // reset with 3 items in flight
    drive(1, 0, 100, 1); step();
    drive(1, 0, 200, 2); step();
    drive(1, 0, 60, 3);  step();
    drive(0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_r", int'(bus.r), 0);
    exp_q.delete();
    prev_stall = 0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_no_out", ov_seen, 0);
    end

    // SCALE_SHIFT = 0 instance: saturation and pass-through at 90 deg
    bus0.in_valid = 1'b1; bus0.y = 8'd100; bus0.theta = 4'd1;
    exp0_q.push_back(model(0, 100, 1, 0));
    @(posedge clock); #1;
    bus0.y = 8'd100; bus0.theta = 4'd6;
    exp0_q.push_back(model(0, 100, 6, 0));
    @(posedge clock); #1;
    bus0.in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (bus0.out_valid && exp0_q.size() > 0) begin
        exp_t e;
        e = exp0_q.pop_front();
        chk("sh0_r", int'(bus0.r), e.r);
        chk("sh0_sat", int'(bus0.sat), e.sat);
      end else if (bus0.out_valid) begin
        chk("sh0_spurious", int'(bus0.out_valid), 0);
      end
    end
    chk("sh0_drain", exp0_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
